// File: rtl/thre_load_pkg.sv
`default_nettype none
// ============================================================================
// Module      : thre_load_pkg
// Description : Shared defaults, FSM state encoding and ROM latency limits
//               for the threshold-load sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package thre_load_pkg;

    localparam int DEF_N_CH    = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_BANK_W  = 2;

    localparam int ROM_LAT_MIN = 1;
    localparam int ROM_LAT_MAX = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : thre_load_pkg
`default_nettype wire

// File: rtl/thre_lat_pipe.sv
`default_nettype none
// ============================================================================
// Module      : thre_lat_pipe
// Description : Delay line for (valid, idx) matching the threshold ROM read
//               latency, with a drain-complete flag.
// Revision    : 1.0 - initial release
// ============================================================================
module thre_lat_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_empty
);

    logic [DEPTH-1:0] r_valid;
    logic [IDX_W-1:0] r_idx [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_idx[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_idx[0]   <= i_idx;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_idx[i]   <= r_idx[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_idx   = r_idx[DEPTH-1];

    // Empty means nothing is queued behind the output stage, so the pipe is
    // fully drained after the current cycle.
    generate
        if (DEPTH == 1) begin : g_single
            assign o_empty = 1'b1;
        end else begin : g_multi
            assign o_empty = ~|r_valid[DEPTH-2:0];
        end
    endgenerate

endmodule : thre_lat_pipe
`default_nettype wire

// File: rtl/thre_load_seq.sv
`default_nettype none
// ============================================================================
// Module      : thre_load_seq
// Description : Reads one threshold word per channel from the threshold ROM
//               and issues latency-aligned one-hot load strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module thre_load_seq
    import thre_load_pkg::*;
#(
    parameter int N_CH      = DEF_N_CH,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BANK_W    = DEF_BANK_W,
    parameter int ROM_LAT   = 1,
    parameter int AUTO_LOAD = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [BANK_W-1:0]        i_bank,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_rom_en,
    output logic [BANK_W+ADDR_W-1:0] o_rom_addr,
    output logic [N_CH-1:0]          o_load_strb,
    input  logic                     i_pool_val_in,
    output logic                     o_pool_val_out
);

    localparam int C_LAT = (ROM_LAT < ROM_LAT_MIN) ? ROM_LAT_MIN :
                           (ROM_LAT > ROM_LAT_MAX) ? ROM_LAT_MAX : ROM_LAT;
    localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(N_CH - 1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_idx;
    logic [BANK_W-1:0]   r_bank;
    logic                r_loaded;
    logic                r_auto;
    logic                w_accept;
    logic [BANK_W-1:0]   w_start_bank;
    logic                w_pipe_valid;
    logic [ADDR_W-1:0]   w_pipe_idx;
    logic                w_pipe_empty;

    // The reset-armed auto request behaves as a bank-0 start on the first
    // edge after reset release.
    assign w_start_bank = r_auto ? '0 : i_bank;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start || r_auto) begin
                    w_accept = 1'b1;
                    w_next   = FETCH;
                end
            end
            FETCH: begin
                if (r_idx == C_LAST_IDX) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pipe_empty) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    w_next   = FETCH;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_bank   <= '0;
            r_loaded <= 1'b0;
            r_auto   <= (AUTO_LOAD != 0);
        end else begin
            r_state <= w_next;
            r_auto  <= 1'b0;
            if (w_accept) begin
                r_bank   <= w_start_bank;
                r_idx    <= '0;
                r_loaded <= 1'b0;
            end else if (r_state == FETCH) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == DRAIN && w_next == DONE) begin
                r_loaded <= 1'b1;
            end
        end
    end

    thre_lat_pipe #(
        .DEPTH (C_LAT),
        .IDX_W (ADDR_W)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_state == FETCH),
        .i_idx   (r_idx),
        .o_valid (w_pipe_valid),
        .o_idx   (w_pipe_idx),
        .o_empty (w_pipe_empty)
    );

    assign o_busy         = (r_state != IDLE);
    assign o_done         = (r_state == DONE);
    assign o_rom_en       = (r_state == FETCH);
    assign o_rom_addr     = (r_state == FETCH) ? {r_bank, r_idx} : '0;
    assign o_load_strb    = w_pipe_valid ? (N_CH'(1) << w_pipe_idx) : '0;
    assign o_pool_val_out = i_pool_val_in & r_loaded;

endmodule : thre_load_seq
`default_nettype wire
